// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the router-to-router credit link.
// The per-stage record depends on module parameters, so it is declared inside noc_credit_link.
package noc_link_pkg;

    // What the monitor sees on one channel in one cycle: {send, credit}.
    typedef enum logic [1:0] {
        EV_IDLE   = 2'b00,
        EV_CREDIT = 2'b01,
        EV_SEND   = 2'b10,
        EV_BOTH   = 2'b11
    } credit_event_e;

    function automatic int credit_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic credit_event_e classify_event(input logic send, input logic credit);
        return credit_event_e'({send, credit});
    endfunction

endpackage

// File: rtl/noc_link_credit_monitor.sv
// One channel's credit tracker: flags sends without credit or credits beyond the buffer depth,
// and keeps saturating flit and packet counters.
module noc_link_credit_monitor
    import noc_link_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  send,
    input  logic                  is_tail,
    input  logic                  credit,
    input  logic                  stat_clear,
    output logic                  credit_err,
    output logic [STAT_WIDTH-1:0] flit_count,
    output logic [STAT_WIDTH-1:0] pkt_count
);

    localparam int            CW       = credit_cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [CW-1:0]         cnt_reg;
    logic                  err_reg;
    logic [STAT_WIDTH-1:0] flit_reg;
    logic [STAT_WIDTH-1:0] pkt_reg;
    credit_event_e         ev;

    assign ev = classify_event(send, credit);

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg  <= CNT_FULL;
            err_reg  <= 1'b0;
            flit_reg <= '0;
            pkt_reg  <= '0;
        end else begin
            // A simultaneous send and credit cancel out, even at the empty/full limits.
            case (ev)
                EV_SEND: begin
                    if (cnt_reg == '0) err_reg <= 1'b1;
                    else               cnt_reg <= cnt_reg - 1'b1;
                end
                EV_CREDIT: begin
                    if (cnt_reg == CNT_FULL) err_reg <= 1'b1;
                    else                     cnt_reg <= cnt_reg + 1'b1;
                end
                default: ;
            endcase

            if (stat_clear) begin
                err_reg  <= 1'b0;
                flit_reg <= '0;
                pkt_reg  <= '0;
            end else begin
                if (send && (flit_reg != '1))
                    flit_reg <= flit_reg + 1'b1;
                if (send && is_tail && (pkt_reg != '1))
                    pkt_reg <= pkt_reg + 1'b1;
            end
        end
    end

    assign credit_err = err_reg;
    assign flit_count = flit_reg;
    assign pkt_count  = pkt_reg;

endmodule

// File: rtl/noc_credit_link.sv
// Multi-channel retiming link between two mesh routers: forward flits and reverse credits are
// delayed by independent depths, and each channel carries its own credit monitor.
module noc_credit_link
    import noc_link_pkg::*;
#(
    parameter int NUM_LINKS         = 4,
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 6,
    parameter int NUM_PIPELINE      = 2,
    parameter int CREDIT_PIPELINE   = NUM_PIPELINE,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int STAT_WIDTH        = 32
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0] data_in     [NUM_LINKS],
    input  logic [DEST_WIDTH-1:0] dest_in     [NUM_LINKS],
    input  logic                  is_tail_in  [NUM_LINKS],
    input  logic                  send_in     [NUM_LINKS],
    output logic                  credit_out  [NUM_LINKS],
    output logic [FLIT_WIDTH-1:0] data_out    [NUM_LINKS],
    output logic [DEST_WIDTH-1:0] dest_out    [NUM_LINKS],
    output logic                  is_tail_out [NUM_LINKS],
    output logic                  send_out    [NUM_LINKS],
    input  logic                  credit_in   [NUM_LINKS],
    input  logic                  stat_clear,
    output logic                  credit_err  [NUM_LINKS],
    output logic [STAT_WIDTH-1:0] flit_count  [NUM_LINKS],
    output logic [STAT_WIDTH-1:0] pkt_count   [NUM_LINKS]
);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
        logic                  send;
    } stage_t;

    for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_link
        stage_t fwd_head;
        stage_t fwd_tail;
        logic   credit_tail;

        assign fwd_head = '{data: data_in[gi], dest: dest_in[gi],
                            is_tail: is_tail_in[gi], send: send_in[gi]};

        if (NUM_PIPELINE == 0) begin : g_fwd_wire
            assign fwd_tail = fwd_head;
        end else begin : g_fwd_pipe
            stage_t fwd_reg [NUM_PIPELINE];

            // Payload is cleared on reset too, so nothing stale can surface afterwards.
            always_ff @(posedge clk_noc) begin
                if (rst_noc_sync) begin
                    for (int i = 0; i < NUM_PIPELINE; i++) fwd_reg[i] <= '0;
                end else begin
                    fwd_reg[0] <= fwd_head;
                    for (int i = 1; i < NUM_PIPELINE; i++) fwd_reg[i] <= fwd_reg[i-1];
                end
            end

            assign fwd_tail = fwd_reg[NUM_PIPELINE-1];
        end

        if (CREDIT_PIPELINE == 0) begin : g_credit_wire
            assign credit_tail = credit_in[gi];
        end else begin : g_credit_pipe
            logic credit_reg [CREDIT_PIPELINE];

            always_ff @(posedge clk_noc) begin
                if (rst_noc_sync) begin
                    for (int i = 0; i < CREDIT_PIPELINE; i++) credit_reg[i] <= 1'b0;
                end else begin
                    credit_reg[0] <= credit_in[gi];
                    for (int i = 1; i < CREDIT_PIPELINE; i++) credit_reg[i] <= credit_reg[i-1];
                end
            end

            assign credit_tail = credit_reg[CREDIT_PIPELINE-1];
        end

        assign data_out[gi]    = fwd_tail.data;
        assign dest_out[gi]    = fwd_tail.dest;
        assign is_tail_out[gi] = fwd_tail.is_tail;
        assign send_out[gi]    = fwd_tail.send;
        assign credit_out[gi]  = credit_tail;

        // The monitor watches the upstream router's view: its own sends and the credits it receives.
        noc_link_credit_monitor #(
            .DEPTH      (FLIT_BUFFER_DEPTH),
            .STAT_WIDTH (STAT_WIDTH)
        ) u_monitor (
            .clk        (clk_noc),
            .srst       (rst_noc_sync),
            .send       (send_in[gi]),
            .is_tail    (is_tail_in[gi]),
            .credit     (credit_tail),
            .stat_clear (stat_clear),
            .credit_err (credit_err[gi]),
            .flit_count (flit_count[gi]),
            .pkt_count  (pkt_count[gi])
        );
    end

endmodule

// File: tb/tb_noc_credit_link.sv
// Bench for noc_credit_link: a history-based model of delays and credit accounting checked every
// cycle, plus directed scenarios with literal expectations.
module tb_noc_credit_link;

    localparam int NL   = 4;
    localparam int FW   = 64;
    localparam int DW   = 6;
    localparam int NP   = 2;
    localparam int CP   = 3;
    localparam int DEP  = 8;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stat_clear = 1'b0;
    logic [FW-1:0] data_in     [NL];
    logic [DW-1:0] dest_in     [NL];
    logic          is_tail_in  [NL];
    logic          send_in     [NL];
    logic          credit_in   [NL];
    logic          credit_out  [NL];
    logic [FW-1:0] data_out    [NL];
    logic [DW-1:0] dest_out    [NL];
    logic          is_tail_out [NL];
    logic          send_out    [NL];
    logic          credit_err  [NL];
    logic [SW-1:0] flit_count  [NL];
    logic [SW-1:0] pkt_count   [NL];

    noc_credit_link #(
        .NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(NP),
        .CREDIT_PIPELINE(CP), .FLIT_BUFFER_DEPTH(DEP), .STAT_WIDTH(SW)
    ) dut (
        .clk_noc(clk), .rst_noc_sync(rst),
        .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
        .credit_out(credit_out), .data_out(data_out), .dest_out(dest_out),
        .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in),
        .stat_clear(stat_clear), .credit_err(credit_err),
        .flit_count(flit_count), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Input history per cycle; outputs are derived from it by pure delay arithmetic.
    logic          rst_h  [MAXC];
    logic          send_h [MAXC][NL];
    logic          tail_h [MAXC][NL];
    logic          cr_h   [MAXC][NL];
    logic [FW-1:0] data_h [MAXC][NL];
    logic [DW-1:0] dest_h [MAXC][NL];

    int m_cnt  [NL] = '{default: DEP};
    int m_err  [NL] = '{default: 0};
    int m_flit [NL] = '{default: 0};
    int m_pkt  [NL] = '{default: 0};

    // True when an input taken in cycle c-d reaches the output in cycle c with no reset in between.
    function automatic bit live(input int c, input int d);
        if (c - d < 0) return 1'b0;
        for (int k = c - d; k < c; k++) if (rst_h[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_credit(input int ch, input int c);
        return live(c, CP) ? cr_h[c-CP][ch] : 1'b0;
    endfunction

    task automatic chk(input string name, input int ch, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp, input bit verbose);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s ch%0d cycle %0d: got %h, expected %h", name, ch, cyc, act, exp);
        end else if (verbose) begin
            $display("check %s ch%0d cycle %0d: got %h as expected", name, ch, cyc, act);
        end
    endtask

    task automatic lit(input string name, input int ch, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
        chk(name, ch, act, exp, 1'b1);
    endtask

    // Record this cycle's inputs, then advance the credit/statistics model by one cycle.
    always @(posedge clk) begin
        rst_h[cyc] = rst;
        for (int ch = 0; ch < NL; ch++) begin
            automatic logic s  = send_in[ch];
            automatic logic cr = exp_credit(ch, cyc);
            send_h[cyc][ch] = send_in[ch];
            tail_h[cyc][ch] = is_tail_in[ch];
            cr_h[cyc][ch]   = credit_in[ch];
            data_h[cyc][ch] = data_in[ch];
            dest_h[cyc][ch] = dest_in[ch];
            if (rst) begin
                m_cnt[ch] = DEP; m_err[ch] = 0; m_flit[ch] = 0; m_pkt[ch] = 0;
            end else begin
                if (s && !cr) begin
                    if (m_cnt[ch] == 0) m_err[ch] = 1; else m_cnt[ch]--;
                end else if (cr && !s) begin
                    if (m_cnt[ch] == DEP) m_err[ch] = 1; else m_cnt[ch]++;
                end
                if (stat_clear) begin
                    m_err[ch] = 0; m_flit[ch] = 0; m_pkt[ch] = 0;
                end else begin
                    if (s && m_flit[ch] < SMAX) m_flit[ch]++;
                    if (s && is_tail_in[ch] && m_pkt[ch] < SMAX) m_pkt[ch]++;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc >= 3) begin
            for (int ch = 0; ch < NL; ch++) begin
                automatic bit fl = live(cyc, NP);
                chk("send_out", ch, send_out[ch], fl ? send_h[cyc-NP][ch] : 1'b0, 1'b0);
                chk("data_out", ch, data_out[ch], fl ? data_h[cyc-NP][ch] : '0, 1'b0);
                chk("dest_out", ch, FW'(dest_out[ch]), fl ? FW'(dest_h[cyc-NP][ch]) : '0, 1'b0);
                chk("is_tail_out", ch, is_tail_out[ch], fl ? tail_h[cyc-NP][ch] : 1'b0, 1'b0);
                chk("credit_out", ch, credit_out[ch], exp_credit(ch, cyc), 1'b0);
                chk("credit_err", ch, credit_err[ch], FW'(m_err[ch]), 1'b0);
                chk("flit_count", ch, flit_count[ch], FW'(m_flit[ch]), 1'b0);
                chk("pkt_count", ch, pkt_count[ch], FW'(m_pkt[ch]), 1'b0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        stat_clear = 1'b0;
        for (int ch = 0; ch < NL; ch++) begin
            data_in[ch] = '0; dest_in[ch] = '0; is_tail_in[ch] = 1'b0;
            send_in[ch] = 1'b0; credit_in[ch] = 1'b0;
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int ch = 0; ch < NL; ch++) begin
            lit("reset send_out", ch, send_out[ch], 1'b0);
            lit("reset credit_err", ch, credit_err[ch], 1'b0);
            lit("reset flit_count", ch, flit_count[ch], '0);
        end

        // Forward delay of exactly two cycles on channel 1 only.
        send_in[1] = 1'b1; data_in[1] = 64'hDEAD_BEEF; dest_in[1] = 6'h2A;
        tick(); clear_inputs();
        lit("fwd early", 1, send_out[1], 1'b0);
        tick();
        lit("fwd send", 1, send_out[1], 1'b1);
        lit("fwd data", 1, data_out[1], 64'hDEAD_BEEF);
        lit("fwd dest", 1, FW'(dest_out[1]), 64'h2A);
        lit("fwd other", 0, send_out[0], 1'b0);
        lit("fwd other", 2, send_out[2], 1'b0);
        lit("fwd other", 3, send_out[3], 1'b0);
        tick();
        lit("fwd late", 1, send_out[1], 1'b0);

        // Spend two credits on channel 0, then return them through the 3-cycle credit path.
        send_in[0] = 1'b1; tick(); tick(); clear_inputs();
        credit_in[0] = 1'b1; tick(); tick(); clear_inputs();
        lit("credit early", 0, credit_out[0], 1'b0);
        tick(); lit("credit first", 0, credit_out[0], 1'b1);
        tick(); lit("credit second", 0, credit_out[0], 1'b1);
        tick(); lit("credit late", 0, credit_out[0], 1'b0);
        tick(); lit("credit balanced", 0, credit_err[0], 1'b0);

        // Channel 2: eight sends fit the buffer, the ninth is a violation that sticks.
        for (int i = 0; i < DEP; i++) begin send_in[2] = 1'b1; tick(); end
        clear_inputs();
        lit("eight sends", 2, credit_err[2], 1'b0);
        send_in[2] = 1'b1; tick(); clear_inputs();
        lit("ninth send", 2, credit_err[2], 1'b1);
        repeat (3) tick();
        lit("err sticky", 2, credit_err[2], 1'b1);
        stat_clear = 1'b1; tick(); clear_inputs();
        lit("err cleared", 2, credit_err[2], 1'b0);

        // At zero credits, a send coinciding with a returning credit is legal.
        credit_in[2] = 1'b1; tick(); clear_inputs(); tick(); tick();
        lit("credit arrives", 2, credit_out[2], 1'b1);
        send_in[2] = 1'b1; tick(); clear_inputs();
        lit("send+credit at 0", 2, credit_err[2], 1'b0);
        for (int i = 0; i < DEP; i++) begin credit_in[2] = 1'b1; tick(); end
        clear_inputs(); repeat (4) tick();
        lit("refilled to depth", 2, credit_err[2], 1'b0);
        credit_in[2] = 1'b1; tick(); clear_inputs(); repeat (4) tick();
        lit("credit overflow", 2, credit_err[2], 1'b1);

        // Channel 3: 17 flits with every 4th a tail saturates the 4-bit flit counter.
        stat_clear = 1'b1; tick(); clear_inputs();
        for (int i = 0; i < 17; i++) begin
            send_in[3] = 1'b1; is_tail_in[3] = ((i % 4) == 3); tick();
        end
        clear_inputs();
        lit("flit saturate", 3, flit_count[3], 64'hF);
        lit("pkt count", 3, pkt_count[3], 64'd4);
        stat_clear = 1'b1; send_in[3] = 1'b1; is_tail_in[3] = 1'b1; tick(); clear_inputs();
        lit("clear wins flit", 3, flit_count[3], '0);
        lit("clear wins pkt", 3, pkt_count[3], '0);

        // Reset with two flits in flight on channel 1.
        send_in[1] = 1'b1; data_in[1] = 64'h1111; tick();
        send_in[1] = 1'b1; data_in[1] = 64'h2222; rst = 1'b1; tick();
        clear_inputs(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lit("no stale send", 1, send_out[1], 1'b0);
            lit("no stale data", 1, data_out[1], '0);
            tick();
        end
        for (int ch = 0; ch < NL; ch++) lit("err after reset", ch, credit_err[ch], 1'b0);
        credit_in[1] = 1'b1; tick(); clear_inputs(); repeat (4) tick();
        lit("rearmed full", 1, credit_err[1], 1'b1);

        // Mixed traffic on all channels, checked by the model alone.
        for (int i = 0; i < 60; i++) begin
            for (int ch = 0; ch < NL; ch++) begin
                send_in[ch]    = ((i * 7 + ch) % 3) == 0;
                is_tail_in[ch] = ((i + ch) % 5) == 0;
                credit_in[ch]  = ((i * 5 + ch * 3) % 4) == 1;
                data_in[ch]    = {32'(i), 32'(ch * 16 + 5)};
                dest_in[ch]    = DW'(i + ch);
            end
            stat_clear = (i == 41);
            tick();
        end
        clear_inputs();
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
